// File: rtl/c_xbar_ctrl_alloc.sv
// Separable input-first round-robin switch allocator.
// Stage 1 picks one output per input, stage 2 picks one input per output;
// the surviving grants are registered and drive the crossbar ctrl matrix.

// Round-robin pick: first requester at or after ptr, wrapping past n-1 to 0.
module c_xbar_rr_arb #(
  parameter int n  = 5,
  parameter int pw = 3
) (
  input  logic [0:n-1]  req,
  input  logic [pw-1:0] ptr,
  output logic [0:n-1]  gnt
);

  // Scan in priority order and keep only the first hit.
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < n; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

module c_xbar_ctrl_alloc #(
  parameter int num_in_ports  = 5,
  parameter int num_out_ports = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [0:num_in_ports*num_out_ports-1]  req_ip_op,
  input  logic [0:num_out_ports-1]               ready_op,
  output logic [0:num_in_ports*num_out_ports-1]  gnt_ip_op,
  output logic [0:num_in_ports-1]                gnt_ip
);

  // in_ptr selects among outputs, out_ptr among inputs; a single-entry
  // dimension still gets a 1-bit pointer that can only ever hold 0.
  localparam int ipw = (num_out_ports > 1) ? $clog2(num_out_ports) : 1;
  localparam int opw = (num_in_ports  > 1) ? $clog2(num_in_ports)  : 1;

  logic [num_in_ports-1:0][ipw-1:0]          in_ptr, in_ptr_nxt;
  logic [num_out_ports-1:0][opw-1:0]         out_ptr, out_ptr_nxt;
  logic [num_in_ports-1:0][0:num_out_ports-1] ereq, s1, g;
  logic [num_out_ports-1:0][0:num_in_ports-1] s1_t, g_t;
  logic [0:num_in_ports*num_out_ports-1]      g_flat;
  logic [0:num_in_ports-1]                    g_row;

  // Stage 1: per-input arbitration over ready-masked requests.
  for (genvar i = 0; i < num_in_ports; i++) begin : g_in
    assign ereq[i] = req_ip_op[i*num_out_ports +: num_out_ports] & ready_op;

    c_xbar_rr_arb #(.n(num_out_ports), .pw(ipw)) u_in_arb (
      .req (ereq[i]),
      .ptr (in_ptr[i]),
      .gnt (s1[i])
    );

    assign g_flat[i*num_out_ports +: num_out_ports] = g[i];
    assign g_row[i] = |g[i];
  end

  // Transpose between row-major (per input) and column-major (per output).
  for (genvar i = 0; i < num_in_ports; i++) begin : g_tr_i
    for (genvar o = 0; o < num_out_ports; o++) begin : g_tr_o
      assign s1_t[o][i] = s1[i][o];
      assign g[i][o]    = g_t[o][i];
    end
  end

  // Stage 2: per-output arbitration among inputs whose stage-1 pick it was.
  for (genvar o = 0; o < num_out_ports; o++) begin : g_out
    c_xbar_rr_arb #(.n(num_in_ports), .pw(opw)) u_out_arb (
      .req (s1_t[o]),
      .ptr (out_ptr[o]),
      .gnt (g_t[o])
    );
  end

  // Pointers advance past the winner only on a final grant, so a stage-1
  // pick that loses in stage 2 keeps its priority for the next cycle.
  always_comb begin
    in_ptr_nxt  = in_ptr;
    out_ptr_nxt = out_ptr;
    for (int i = 0; i < num_in_ports; i++) begin
      for (int o = 0; o < num_out_ports; o++) begin
        if (g[i][o]) begin
          in_ptr_nxt[i]  = (o == num_out_ports-1) ? '0 : ipw'(o + 1);
          out_ptr_nxt[o] = (i == num_in_ports-1)  ? '0 : opw'(i + 1);
        end
      end
    end
  end

  // Register grants and pointers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_ip_op <= '0;
      gnt_ip    <= '0;
      in_ptr    <= '0;
      out_ptr   <= '0;
    end else begin
      gnt_ip_op <= g_flat;
      gnt_ip    <= g_row;
      in_ptr    <= in_ptr_nxt;
      out_ptr   <= out_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_c_xbar_ctrl_alloc.sv
// Bench for c_xbar_ctrl_alloc: a behavioural allocator model pushes the
// expected grant for every applied input; tests pop and compare one cycle later.
module tb_c_xbar_ctrl_alloc;

  localparam int NI = 5;
  localparam int NO = 5;
  localparam int NB = NI * NO;

  typedef struct {
    logic [0:NB-1] gnt;
    logic [0:NI-1] gip;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [0:NB-1] req;
  logic [0:NO-1] rdy;
  logic [0:NB-1] gnt;
  logic [0:NI-1] gnt_ip;

  exp_t          exp_q[$];
  int            m_in[NI];
  int            m_out[NO];
  logic [0:NB-1] prev_req;
  logic [0:NO-1] prev_rdy;

  int vectors    = 0;
  int miscompares = 0;

  c_xbar_ctrl_alloc #(.num_in_ports(NI), .num_out_ports(NO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_ip_op (req),
    .ready_op  (rdy),
    .gnt_ip_op (gnt),
    .gnt_ip    (gnt_ip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NI; i++) m_in[i] = 0;
    for (int o = 0; o < NO; o++) m_out[o] = 0;
    exp_q.delete();
  endtask

  // Reference allocator: compute grant for (r, y), advance model pointers, push.
  task automatic model_push(input logic [0:NB-1] r, input logic [0:NO-1] y);
    int   pick[NI];
    int   win;
    int   c;
    exp_t e;
    e.gnt = '0;
    e.gip = '0;
    for (int i = 0; i < NI; i++) begin
      pick[i] = -1;
      for (int k = 0; k < NO; k++) begin
        c = (m_in[i] + k) % NO;
        if (pick[i] < 0 && r[i*NO+c] && y[c]) pick[i] = c;
      end
    end
    for (int o = 0; o < NO; o++) begin
      win = -1;
      for (int k = 0; k < NI; k++) begin
        c = (m_out[o] + k) % NI;
        if (win < 0 && pick[c] == o) win = c;
      end
      if (win >= 0) begin
        e.gnt[win*NO+o] = 1'b1;
        e.gip[win]      = 1'b1;
        m_in[win] = (o + 1) % NO;
        m_out[o]  = (win + 1) % NI;
      end
    end
    exp_q.push_back(e);
  endtask

  // Apply one cycle of stimulus; returns #1 after the sampling edge.
  task automatic drive(input logic [0:NB-1] r, input logic [0:NO-1] y);
    req = r;
    rdy = y;
    model_push(r, y);
    prev_req = r;
    prev_rdy = y;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    rdy   = '1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    exp_t e;
    logic [0:NB-1] r;
    #1;
    vectors++;
    if (gnt !== '0 || gnt_ip !== '0) begin
      miscompares++;
      $display("FAIL reset_state gnt=%h gnt_ip=%b want 0", gnt, gnt_ip);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      drive('1, '1);
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e.gnt || gnt_ip !== e.gip) begin
        miscompares++;
        $display("FAIL reset_traffic c%0d gnt=%h gip=%b want %h %b", c, gnt, gnt_ip, e.gnt, e.gip);
      end
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (gnt !== '0 || gnt_ip !== '0) begin
      miscompares++;
      $display("FAIL reset_async gnt=%h gnt_ip=%b want 0", gnt, gnt_ip);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    r = '0;
    r[0] = 1'b1;
    drive(r, '1);
    e = exp_q.pop_front();
    vectors++;
    if (gnt !== e.gnt || gnt !== r || gnt_ip !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_first gnt=%h gip=%b want %h 10000", gnt, gnt_ip, r);
    end
  endtask

  task automatic test_single();
    exp_t e;
    logic [0:NB-1] r;
    do_reset();
    r = '0;
    r[13] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive((c == 0) ? r : '0, '1);
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e.gnt || gnt_ip !== e.gip || gnt !== ((c == 0) ? r : '0)) begin
        miscompares++;
        $display("FAIL single c%0d gnt=%h gip=%b want %h", c, gnt, gnt_ip, e.gnt);
      end
    end
    // only the first cycle grants ip2
    vectors++;
    if (e.gip !== 5'b00000) begin
      miscompares++;
      $display("FAIL single_model gip=%b want 00000", e.gip);
    end
  endtask

  task automatic test_out_conflict();
    exp_t e;
    logic [0:NB-1] r;
    logic [0:NI-1] want;
    int seq[3] = '{0, 1, 4};
    do_reset();
    r = '0;
    r[0*NO+1] = 1'b1;
    r[1*NO+1] = 1'b1;
    r[4*NO+1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(r, '1);
      e = exp_q.pop_front();
      want = '0;
      want[seq[c%3]] = 1'b1;
      vectors++;
      if (gnt !== e.gnt || gnt_ip !== want || gnt[seq[c%3]*NO+1] !== 1'b1) begin
        miscompares++;
        $display("FAIL out_conflict c%0d gnt=%h gip=%b want %h %b", c, gnt, gnt_ip, e.gnt, want);
      end
    end
  endtask

  task automatic test_fanout();
    exp_t e;
    logic [0:NB-1] r;
    logic [0:NB-1] want;
    int seq[3] = '{0, 2, 4};
    do_reset();
    r = '0;
    r[3*NO+0] = 1'b1;
    r[3*NO+2] = 1'b1;
    r[3*NO+4] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(r, '1);
      e = exp_q.pop_front();
      want = '0;
      want[3*NO+seq[c%3]] = 1'b1;
      vectors++;
      if (gnt !== e.gnt || gnt !== want || gnt_ip !== 5'b00010) begin
        miscompares++;
        $display("FAIL fanout c%0d gnt=%h gip=%b want %h", c, gnt, gnt_ip, want);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [0:NB-1] r;
    r = '0;
    r[1] = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(r, (c < 3) ? 5'b10111 : 5'b11111);
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e.gnt || gnt_ip !== e.gip || gnt !== ((c < 3) ? '0 : r)) begin
        miscompares++;
        $display("FAIL backpressure c%0d gnt=%h gip=%b want %h", c, gnt, gnt_ip, e.gnt);
      end
    end
  endtask

  task automatic test_full_matrix();
    exp_t e;
    logic [0:NB-1] w0, w1;
    w0 = '0;
    w0[0] = 1'b1;
    w1 = '0;
    w1[1] = 1'b1;
    w1[5] = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive('1, '1);
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e.gnt || gnt_ip !== e.gip ||
          (c == 0 && gnt !== w0) || (c == 1 && gnt !== w1)) begin
        miscompares++;
        $display("FAIL full_matrix c%0d gnt=%h gip=%b want %h", c, gnt, gnt_ip, e.gnt);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [0:NB-1] r;
    logic [0:NO-1] y;
    logic [0:NB-1] ok;
    int rc, cc;
    logic bad;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) r[b] = ($urandom_range(0, 2) == 0);
      for (int o = 0; o < NO; o++) y[o] = ($urandom_range(0, 4) != 0);
      if (c == 1500) begin
        do_reset();
      end
      drive(r, y);
      e = exp_q.pop_front();
      vectors++;
      if (gnt !== e.gnt || gnt_ip !== e.gip) begin
        miscompares++;
        $display("FAIL random c%0d gnt=%h gip=%b want %h %b", c, gnt, gnt_ip, e.gnt, e.gip);
      end
      bad = 1'b0;
      for (int i = 0; i < NI; i++) begin
        rc = 0;
        for (int o = 0; o < NO; o++) rc += int'(gnt[i*NO+o]);
        if (rc > 1 || gnt_ip[i] !== (rc != 0)) bad = 1'b1;
      end
      for (int o = 0; o < NO; o++) begin
        cc = 0;
        for (int i = 0; i < NI; i++) cc += int'(gnt[i*NO+o]);
        if (cc > 1) bad = 1'b1;
      end
      for (int b = 0; b < NB; b++) ok[b] = prev_req[b] & prev_rdy[b%NO];
      if ((gnt & ~ok) !== '0) bad = 1'b1;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL invariant c%0d gnt=%h gip=%b req=%h rdy=%b", c, gnt, gnt_ip, prev_req, prev_rdy);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    rdy   = '1;
    prev_req = '0;
    prev_rdy = '0;
    test_reset();
    test_single();
    test_out_conflict();
    test_fanout();
    test_backpressure();
    test_full_matrix();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
